// File: rtl/spam_arbiter.sv
// Round-robin arbiter sharing one SPAM master port among N_REQ requesters.
// Optional watchdog on the WAIT state is enabled with `define SPAM_ARB_TIMEOUT_EN.
module spam_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DID_W   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_r_nw,
    input  logic [N_REQ*DID_W-1:0]    req_did,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      spamo_valid,
    output logic                      spamo_r_nw,
    output logic [DID_W-1:0]          spamo_did,
    output logic [ADDR_W-1:0]         spamo_addr,
    output logic [DATA_W-1:0]         spamo_data,
    input  logic                      spami_busy_b,
    input  logic [DATA_W-1:0]         spami_data,
    output logic                      arb_busy,
    output logic [1:0]                dbg_state
);

    // Handshake: a requester raises req_valid with a stable payload and holds it
    // until its one-cycle req_done pulse; the SPAM side gets a one-cycle
    // spamo_valid strobe and reports completion by raising spami_busy_b.

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             found;
    int               pick_sum;

    assign dbg_state = state;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        any_req  = |req_valid;
        pick_idx = '0;
        found    = 1'b0;
        pick_sum = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pick_sum = int'(rr_ptr) + k;
            if (pick_sum >= N_REQ) pick_sum = pick_sum - N_REQ;
            if (!found && req_valid[pick_sum]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(pick_sum);
            end
        end
    end

`ifdef SPAM_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_q;
    assign req_err = err_q;
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            spamo_valid <= 1'b0;
            spamo_r_nw  <= 1'b0;
            spamo_did   <= '0;
            spamo_addr  <= '0;
            spamo_data  <= '0;
            req_done    <= '0;
            req_rdata   <= '0;
            arb_busy    <= 1'b0;
`ifdef SPAM_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            spamo_valid <= 1'b0;
            req_done    <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant       <= pick_idx;
                        spamo_r_nw  <= req_r_nw[pick_idx];
                        spamo_did   <= req_did[pick_idx*DID_W +: DID_W];
                        spamo_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        spamo_data  <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        spamo_valid <= 1'b1;
                        arb_busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SPAM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (spami_busy_b) begin
                        req_rdata <= spamo_r_nw ? spami_data : '0;
                        req_done  <= {{(N_REQ-1){1'b0}}, 1'b1} << grant;
`ifdef SPAM_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= DONE;
                    end
`ifdef SPAM_ARB_TIMEOUT_EN
                    // The WAIT cycle in which the count reaches TIMEOUT-1 is the last one.
                    else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        req_rdata <= '1;
                        req_done  <= {{(N_REQ-1){1'b0}}, 1'b1} << grant;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    if (int'(grant) == N_REQ - 1) rr_ptr <= '0;
                    else                          rr_ptr <= grant + 1'b1;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spam_arbiter.sv
// Scoreboard bench for spam_arbiter: drivers push expected SPAM issues and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_spam_arbiter;

    localparam int N_REQ   = 2;
    localparam int DID_W   = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int IW      = 1 + DID_W + ADDR_W + DATA_W;
    localparam int DW      = 1 + N_REQ + DATA_W;

    logic                    clk;
    logic                    rst_b;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_r_nw;
    logic [N_REQ*DID_W-1:0]  req_did;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_done;
    logic [DATA_W-1:0]       req_rdata;
    logic                    req_err;
    logic                    spamo_valid;
    logic                    spamo_r_nw;
    logic [DID_W-1:0]        spamo_did;
    logic [ADDR_W-1:0]       spamo_addr;
    logic [DATA_W-1:0]       spamo_data;
    logic                    spami_busy_b;
    logic [DATA_W-1:0]       spami_data;
    logic                    arb_busy;
    logic [1:0]              dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [IW-1:0] iss_q[$];
    logic [DW-1:0] exp_q[$];
    logic [IW-1:0] mon_iss;
    logic [DW-1:0] mon_done;

    spam_arbiter #(
        .N_REQ(N_REQ), .DID_W(DID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_r_nw(req_r_nw), .req_did(req_did),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
        .spamo_valid(spamo_valid), .spamo_r_nw(spamo_r_nw), .spamo_did(spamo_did),
        .spamo_addr(spamo_addr), .spamo_data(spamo_data),
        .spami_busy_b(spami_busy_b), .spami_data(spami_data),
        .arb_busy(arb_busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [IW-1:0] mk_iss(bit r, logic [DID_W-1:0] did,
                                             logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wd);
        return {r, did, addr, wd};
    endfunction

    function automatic logic [DW-1:0] mk_done(int idx, logic [DATA_W-1:0] rd, bit err);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return {err, oh, rd};
    endfunction

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_b) begin
            if (spamo_valid) begin
                checks++;
                if (iss_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue: unexpected strobe got %0h expected none",
                             {spamo_r_nw, spamo_did, spamo_addr, spamo_data});
                end else begin
                    mon_iss = iss_q.pop_front();
                    if ({spamo_r_nw, spamo_did, spamo_addr, spamo_data} !== mon_iss) begin
                        errors++;
                        $display("FAIL issue: got %0h expected %0h",
                                 {spamo_r_nw, spamo_did, spamo_addr, spamo_data}, mon_iss);
                    end
                end
            end
            if (req_done != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done: unexpected pulse got %0h expected none",
                             {req_err, req_done, req_rdata});
                end else begin
                    mon_done = exp_q.pop_front();
                    if ({req_err, req_done, req_rdata} !== mon_done) begin
                        errors++;
                        $display("FAIL done: got %0h expected %0h",
                                 {req_err, req_done, req_rdata}, mon_done);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic set_req(int i, bit v, bit r, logic [DID_W-1:0] did,
                           logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wd);
        req_valid[i]                    = v;
        req_r_nw[i]                     = r;
        req_did[i*DID_W +: DID_W]       = did;
        req_addr[i*ADDR_W +: ADDR_W]    = addr;
        req_wdata[i*DATA_W +: DATA_W]   = wd;
    endtask

    task automatic wait_issue(output int c);
        c = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (spamo_valid) begin
                c = cyc;
                return;
            end
        end
        bound_fail("wait_issue");
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_done != '0) begin
                c = cyc;
                return;
            end
        end
        bound_fail("wait_done");
    endtask

    task automatic run_txn(int i, bit r, logic [DID_W-1:0] did, logic [ADDR_W-1:0] addr,
                           logic [DATA_W-1:0] wd, int busy_wait, logic [DATA_W-1:0] sdata,
                           bit drop_mid, output int c_drive, output int c_iss, output int c_done);
        iss_q.push_back(mk_iss(r, did, addr, wd));
        exp_q.push_back(mk_done(i, r ? sdata : '0, 1'b0));
        @(negedge clk);
        set_req(i, 1'b1, r, did, addr, wd);
        spami_busy_b = (busy_wait == 0);
        spami_data   = sdata;
        c_drive      = cyc;
        wait_issue(c_iss);
        check("arb_busy_in_txn", 128'(arb_busy), 128'(1));
        for (int k = 0; k < busy_wait; k++) begin
            @(negedge clk);
            if (drop_mid) req_valid[i] = 1'b0;
        end
        spami_busy_b = 1'b1;
        wait_done(c_done);
        req_valid[i] = 1'b0;
        @(negedge clk);
        check("arb_busy_after", 128'(arb_busy), 128'(0));
    endtask

    task automatic run_contention(int n, int start);
        int cnt;
        int idx;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            idx = (start + k) % 2;
            if (idx == 0) begin
                iss_q.push_back(mk_iss(1'b1, 4'h1, 8'h10, 32'h0));
                exp_q.push_back(mk_done(0, 32'hCAFEF00D, 1'b0));
            end else begin
                iss_q.push_back(mk_iss(1'b0, 4'h2, 8'h20, 32'h12345678));
                exp_q.push_back(mk_done(1, 32'h0, 1'b0));
            end
        end
        @(negedge clk);
        spami_busy_b = 1'b1;
        spami_data   = 32'hCAFEF00D;
        set_req(0, 1'b1, 1'b1, 4'h1, 8'h10, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'h2, 8'h20, 32'h12345678);
        for (int k = 0; k < 20 * n; k++) begin
            @(negedge clk);
            if (req_done != '0) begin
                cnt++;
                if (cnt == n) begin
                    req_valid = '0;
                    break;
                end
            end
        end
        check("contention_done_count", 128'(cnt), 128'(n));
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    int c_drive, c_iss, c_done;

    initial begin
        rst_b        = 1'b0;
        req_valid    = '0;
        req_r_nw     = '0;
        req_did      = '0;
        req_addr     = '0;
        req_wdata    = '0;
        spami_busy_b = 1'b1;
        spami_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              128'({spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data,
                    req_done, req_rdata, req_err, arb_busy, dbg_state}), 128'(0));
        @(negedge clk);
        rst_b = 1'b1;

        // single read with 3-cycle busy target
        run_txn(0, 1'b1, 4'h1, 8'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, c_drive, c_iss, c_done);

        // zero-wait write: done 3 cycles after the IDLE sample
        run_txn(1, 1'b0, 4'h3, 8'h44, 32'h12345678, 0, 32'hFFFF0000, 1'b0, c_drive, c_iss, c_done);
        check("write_issue_latency", 128'(c_iss - c_drive), 128'(1));
        check("write_done_latency", 128'(c_done - c_drive), 128'(3));

        // both requesters held: strict alternation starting at requester 0
        run_contention(4, 0);

        // requester 0 drops req_valid during WAIT; transaction must still finish
        run_txn(0, 1'b1, 4'h5, 8'h33, 32'h0, 4, 32'h0BADF00D, 1'b1, c_drive, c_iss, c_done);

        // requester 1 write aborted by reset in WAIT (rr_ptr is 1 here)
        iss_q.push_back(mk_iss(1'b0, 4'h2, 8'h22, 32'h000055AA));
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 4'h2, 8'h22, 32'h000055AA);
        spami_busy_b = 1'b0;
        wait_issue(c_iss);
        @(negedge clk);
        @(negedge clk);
        check("state_before_reset", 128'(dbg_state), 128'(2));
        #2 rst_b = 1'b0;
        #1;
        check("midflight_reset_outputs",
              128'({spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data,
                    req_done, req_rdata, req_err, arb_busy, dbg_state}), 128'(0));
        req_valid = '0;
        spami_busy_b = 1'b1;
        @(negedge clk);
        check("no_done_during_reset", 128'(req_done), 128'(0));
        rst_b = 1'b1;

        // rr_ptr restarts at 0: requester 0 wins first
        run_contention(2, 0);

`ifdef SPAM_ARB_TIMEOUT_EN
        iss_q.push_back(mk_iss(1'b1, 4'h7, 8'h70, 32'h0));
        exp_q.push_back(mk_done(0, 32'hFFFFFFFF, 1'b1));
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 4'h7, 8'h70, 32'h0);
        spami_busy_b = 1'b0;
        wait_issue(c_iss);
        wait_done(c_done);
        req_valid[0] = 1'b0;
        check("timeout_latency", 128'(c_done - c_iss), 128'(TIMEOUT + 1));
        spami_busy_b = 1'b1;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("issue_queue_empty", 128'(iss_q.size()), 128'(0));
        check("done_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
